// File: rtl/comp_serial_ctrl.sv
// Serial magnitude comparator: one SLICE-bit compare per cycle, scanned MSB-first,
// stopping at the first unequal slice. Valid/ready handshakes on both sides.
module comp_serial_ctrl #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  A,
  input  logic [WIDTH-1:0]                  B,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_A_G_B,
  output logic                              out_A_E_B,
  output logic                              out_A_L_B,
  output logic [$clog2(WIDTH/SLICE+1)-1:0]  slices_used
);

  localparam int N    = WIDTH / SLICE;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(N + 1);
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              gt_q, gt_d;
  logic              eq_q, eq_d;
  logic              lt_q, lt_d;

  // Slice views of the registered operands; idx selects the one under test.
  logic [SLICE-1:0]  a_sl [N];
  logic [SLICE-1:0]  b_sl [N];
  logic [SLICE-1:0]  a_cur, b_cur;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign a_sl[gi] = a_q[gi*SLICE +: SLICE];
      assign b_sl[gi] = b_q[gi*SLICE +: SLICE];
    end
  endgenerate

  assign a_cur = a_sl[idx_q];
  assign b_cur = b_sl[idx_q];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          idx_d   = IDX_TOP;
          cnt_d   = '0;
          gt_d    = 1'b0;
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = CMP;
        end
      end
      CMP: begin
        cnt_d = cnt_q + CNTW'(1);
        if (a_cur > b_cur) begin
          gt_d    = 1'b1;
          state_d = DONE;
        end else if (a_cur < b_cur) begin
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDXW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_A_G_B   = gt_q;
  assign out_A_E_B   = eq_q;
  assign out_A_L_B   = lt_q;
  assign slices_used = cnt_q;

endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Bench for comp_serial_ctrl: directed corner cases then randomized operand pairs
// checked against an arithmetic reference (unsigned compare, highest differing bit).
module tb_comp_serial_ctrl;

  localparam int WIDTH = 16;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  A = '0;
  logic [WIDTH-1:0]  B = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              out_A_G_B, out_A_E_B, out_A_L_B;
  logic [2:0]        slices_used;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  comp_serial_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .A           (A),
    .B           (B),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_A_G_B   (out_A_G_B),
    .out_A_E_B   (out_A_E_B),
    .out_A_L_B   (out_A_L_B),
    .slices_used (slices_used)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slices examined = N minus the slice index holding the highest differing bit.
  function automatic int exp_k(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    int msb;
    x   = a ^ b;
    msb = -1;
    for (int i = 0; i < WIDTH; i++) if (x[i]) msb = i;
    if (msb < 0) return N;
    return N - msb / SLICE;
  endfunction

  function automatic logic [2:0] exp_flags(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input int gap, input int hold, input bit poke, input bit rdy_early);
    int lat;
    logic [2:0] ef;
    int ek;
    ef = exp_flags(a, b);
    ek = exp_k(a, b);
    repeat (gap) step();
    chk("idle_ready", in_ready, 1);
    A = a;
    B = b;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    A = WIDTH'($urandom);
    B = WIDTH'($urandom);
    if (rdy_early) out_ready = 1'b1;
    chk("cmp_ready", in_ready, 0);
    chk("cmp_valid", out_valid, 0);
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < N + 2);
    chk("latency", lat, ek);
    chk("done_valid", out_valid, 1);
    chk("flags", {out_A_G_B, out_A_E_B, out_A_L_B}, ef);
    chk("slices", slices_used, ek);
    if (!rdy_early) begin
      for (int h = 0; h < hold; h++) begin
        if (poke) begin
          in_valid = 1'b1;
          A = WIDTH'($urandom);
          B = WIDTH'($urandom);
        end
        step();
        chk("hold_valid", out_valid, 1);
        chk("hold_ready", in_ready, 0);
        chk("hold_flags", {out_A_G_B, out_A_E_B, out_A_L_B}, ef);
        chk("hold_slices", slices_used, ek);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("post_valid", out_valid, 0);
    chk("post_ready", in_ready, 1);
    chk("post_flags", {out_A_G_B, out_A_E_B, out_A_L_B}, ef);
    chk("post_slices", slices_used, ek);
    $display("op A=%04h B=%04h flags=%03b slices=%0d lat=%0d", a, b,
             {out_A_G_B, out_A_E_B, out_A_L_B}, slices_used, lat);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [31:0] mask;
    int j;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_flags", {out_A_G_B, out_A_E_B, out_A_L_B}, 3'b000);
    chk("rst_slices", slices_used, 0);
    step();
    @(negedge clk) rst_n = 1'b1;
    step();

    // Reset asserted in the middle of a scan discards the result.
    A = 16'h1234;
    B = 16'h1235;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ready", in_ready, 1);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_flags", {out_A_G_B, out_A_E_B, out_A_L_B}, 3'b000);
    chk("midrst_slices", slices_used, 0);
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("midrst_noresult", out_valid, 0);
    end
    out_ready = 1'b0;
    $display("reset mid-scan checked");

    do_op(16'h9000, 16'h1FFF, 0, 0, 1'b0, 1'b1);
    do_op(16'h1234, 16'h1235, 1, 0, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'hFFFF, 0, 1, 1'b0, 1'b0);
    do_op(16'h0000, 16'h0000, 0, 0, 1'b0, 1'b0);
    do_op(16'h0100, 16'h00FF, 0, 5, 1'b1, 1'b0);

    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        rb = WIDTH'($urandom);
      end else begin
        j = $urandom_range(0, N);
        mask = (32'd1 << (j * SLICE)) - 32'd1;
        rb = ra ^ WIDTH'($urandom & mask);
      end
      do_op(ra, rb, $urandom_range(0, 2), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
